// File: rtl/isi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// isi_pkg : shared types and helpers for the banked ISI channel model
// Rev 1.0
// ---------------------------------------------------------------------------
package isi_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_RUN   = 2'd1,
      ST_PEND  = 2'd2,
      ST_SWAP  = 2'd3
   } isi_state_t;

   // Width that holds NUM_TAPS full-precision products without overflow.
   function automatic int calc_acc_w(input int sig_w, input int coef_w, input int num_taps);
      return sig_w + coef_w + $clog2(num_taps);
   endfunction

   function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/isi_channel_banked_coef.sv
`default_nettype none
// ---------------------------------------------------------------------------
// isi_coef_bank : active/shadow tap storage, pending shift and write port
// Rev 1.0
// ---------------------------------------------------------------------------
module isi_coef_bank
   import isi_pkg::*;
#(
   parameter int NUM_TAPS = 5,
   parameter int COEF_W   = 8,
   parameter int SHIFT_W  = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [$clog2(NUM_TAPS)-1:0] wr_addr,
   input  logic [COEF_W-1:0]           wr_data,
   input  logic                        commit_en,
   input  logic [SHIFT_W-1:0]          shift_in,
   input  logic                        swap_en,
   output logic [COEF_W-1:0]           taps [NUM_TAPS],
   output logic [SHIFT_W-1:0]          shift_out,
   output logic                        active_bank,
   output logic                        wr_err
);

   logic [COEF_W-1:0]  bank0_q [NUM_TAPS];
   logic [COEF_W-1:0]  bank0_d [NUM_TAPS];
   logic [COEF_W-1:0]  bank1_q [NUM_TAPS];
   logic [COEF_W-1:0]  bank1_d [NUM_TAPS];
   logic               active_q, active_d;
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic [SHIFT_W-1:0] pend_q, pend_d;
   logic               wr_err_q, wr_err_d;

   always_comb begin
      bank0_d  = bank0_q;
      bank1_d  = bank1_q;
      active_d = active_q;
      shift_d  = shift_q;
      pend_d   = pend_q;
      wr_err_d = wr_err_q;
      if (wr_en) begin
         if (int'(wr_addr) < NUM_TAPS) begin
            if (active_q)
               bank0_d[wr_addr] = wr_data;
            else
               bank1_d[wr_addr] = wr_data;
         end else begin
            wr_err_d = 1'b1;
         end
      end
      if (commit_en)
         pend_d = shift_in;
      // Old active bank becomes the new shadow, seeded with the promoted taps
      // so later writes can be incremental edits.
      if (swap_en) begin
         active_d = ~active_q;
         shift_d  = pend_q;
         if (active_q)
            bank1_d = bank0_q;
         else
            bank0_d = bank1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            bank0_q[i] <= '0;
            bank1_q[i] <= '0;
         end
         active_q <= 1'b0;
         shift_q  <= '0;
         pend_q   <= '0;
         wr_err_q <= 1'b0;
      end else begin
         bank0_q  <= bank0_d;
         bank1_q  <= bank1_d;
         active_q <= active_d;
         shift_q  <= shift_d;
         pend_q   <= pend_d;
         wr_err_q <= wr_err_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_TAPS; i++)
         taps[i] = active_q ? bank1_q[i] : bank0_q[i];
   end

   assign shift_out   = shift_q;
   assign active_bank = active_q;
   assign wr_err      = wr_err_q;

endmodule
`default_nettype wire

// File: rtl/isi_channel_banked.sv
`default_nettype none
// ---------------------------------------------------------------------------
// isi_channel_banked : transposed-form FIR channel with banked taps, saturation
// Rev 1.0
// ---------------------------------------------------------------------------
module isi_channel_banked
   import isi_pkg::*;
#(
   parameter int NUM_TAPS = 5,
   parameter int SIG_W    = 8,
   parameter int COEF_W   = 8,
   parameter int SHIFT_W  = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [SIG_W-1:0]            sig_in,
   input  logic                        sig_in_valid,
   output logic [SIG_W-1:0]            sig_out,
   output logic                        sig_out_valid,
   input  logic                        coef_wr_valid,
   output logic                        coef_wr_ready,
   input  logic [$clog2(NUM_TAPS)-1:0] coef_wr_addr,
   input  logic [COEF_W-1:0]           coef_wr_data,
   input  logic [SHIFT_W-1:0]          coef_shift,
   input  logic                        coef_commit,
   output logic                        active_bank,
   output logic                        coef_loaded,
   output logic                        sat_flag,
   output logic                        wr_err
);

   localparam int ACC_W = calc_acc_w(SIG_W, COEF_W, NUM_TAPS);

   isi_state_t               state_q, state_d;
   logic                     ready_q, ready_d;
   logic                     loaded_q, loaded_d;
   logic                     sat_q, sat_d;
   logic                     out_valid_q, out_valid_d;
   logic [SIG_W-1:0]         sig_out_q, sig_out_d;
   logic signed [ACC_W-1:0]  isi_q [1:NUM_TAPS-1];
   logic signed [ACC_W-1:0]  isi_d [1:NUM_TAPS-1];

   logic signed [ACC_W-1:0]  prod [NUM_TAPS];
   logic signed [ACC_W-1:0]  sum0, shifted;
   logic signed [63:0]       sat_v;
   logic [COEF_W-1:0]        taps [NUM_TAPS];
   logic [SHIFT_W-1:0]       shift;
   logic                     wr_en, commit_en, swap_en, process;

   assign wr_en     = coef_wr_valid && ready_q;
   assign commit_en = coef_commit && ((state_q == ST_EMPTY) || (state_q == ST_RUN));
   assign swap_en   = (state_q == ST_SWAP);
   assign process   = sig_in_valid && ((state_q == ST_RUN) || (state_q == ST_PEND));

   isi_coef_bank #(
      .NUM_TAPS (NUM_TAPS),
      .COEF_W   (COEF_W),
      .SHIFT_W  (SHIFT_W)
   ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (coef_wr_addr),
      .wr_data     (coef_wr_data),
      .commit_en   (commit_en),
      .shift_in    (coef_shift),
      .swap_en     (swap_en),
      .taps        (taps),
      .shift_out   (shift),
      .active_bank (active_bank),
      .wr_err      (wr_err)
   );

   always_comb begin
      for (int i = 0; i < NUM_TAPS; i++)
         prod[i] = ACC_W'($signed(sig_in)) * ACC_W'($signed(taps[i]));
      sum0    = isi_q[1] + prod[0];
      shifted = sum0 >>> shift;
      sat_v   = sat_to_width(64'(shifted), SIG_W);
   end

   always_comb begin
      state_d     = state_q;
      loaded_d    = loaded_q;
      sat_d       = sat_q;
      sig_out_d   = sig_out_q;
      out_valid_d = process;
      isi_d       = isi_q;

      case (state_q)
         ST_EMPTY: if (coef_commit) state_d = ST_SWAP;
         ST_RUN:   if (coef_commit) state_d = ST_PEND;
         // Promotion waits for a bubble so no sample mixes old and new taps.
         ST_PEND:  if (!sig_in_valid) state_d = ST_SWAP;
         ST_SWAP:  state_d = ST_RUN;
         default:  state_d = ST_EMPTY;
      endcase
      ready_d = (state_d == ST_EMPTY) || (state_d == ST_RUN);

      if (process) begin
         isi_d[NUM_TAPS-1] = prod[NUM_TAPS-1];
         for (int i = 1; i < NUM_TAPS - 1; i++)
            isi_d[i] = isi_q[i+1] + prod[i];
         sig_out_d = sat_v[SIG_W-1:0];
         if (sat_v != 64'(shifted))
            sat_d = 1'b1;
      end

      if (swap_en) begin
         for (int i = 1; i < NUM_TAPS; i++)
            isi_d[i] = '0;
         loaded_d = 1'b1;
         sat_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         ready_q     <= 1'b1;
         loaded_q    <= 1'b0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         sig_out_q   <= '0;
         for (int i = 1; i < NUM_TAPS; i++)
            isi_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         loaded_q    <= loaded_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         sig_out_q   <= sig_out_d;
         isi_q       <= isi_d;
      end
   end

   assign sig_out       = sig_out_q;
   assign sig_out_valid = out_valid_q;
   assign coef_wr_ready = ready_q;
   assign coef_loaded   = loaded_q;
   assign sat_flag      = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_isi_channel_banked.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_isi_channel_banked : directed + random stimulus against a convolution model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_isi_channel_banked;

   localparam int N = 5;
   localparam int M_EMPTY = 0, M_RUN = 1, M_PEND = 2, M_SWAP = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] sig_in = '0;
   logic       sig_in_valid = 1'b0;
   logic [7:0] sig_out;
   logic       sig_out_valid;
   logic       coef_wr_valid = 1'b0;
   logic       coef_wr_ready;
   logic [2:0] coef_wr_addr = '0;
   logic [7:0] coef_wr_data = '0;
   logic [4:0] coef_shift = '0;
   logic       coef_commit = 1'b0;
   logic       active_bank, coef_loaded, sat_flag, wr_err;

   isi_channel_banked #(.NUM_TAPS(N), .SIG_W(8), .COEF_W(8), .SHIFT_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .sig_in        (sig_in),
      .sig_in_valid  (sig_in_valid),
      .sig_out       (sig_out),
      .sig_out_valid (sig_out_valid),
      .coef_wr_valid (coef_wr_valid),
      .coef_wr_ready (coef_wr_ready),
      .coef_wr_addr  (coef_wr_addr),
      .coef_wr_data  (coef_wr_data),
      .coef_shift    (coef_shift),
      .coef_commit   (coef_commit),
      .active_bank   (active_bank),
      .coef_loaded   (coef_loaded),
      .sat_flag      (sat_flag),
      .wr_err        (wr_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: output = convolution of the samples accepted since the last
   // promotion with the active taps, floor-shifted and clamped.
   int      m_state;
   bit      m_bank, m_loaded, m_sat, m_wrerr, m_ready, m_valid;
   longint  m_out;
   longint  m_active [N];
   longint  m_shadow [N];
   int      m_shift, m_pend;
   longint  hist [$];

   task automatic model_reset();
      m_state = M_EMPTY; m_bank = 0; m_loaded = 0; m_sat = 0; m_wrerr = 0;
      m_ready = 1; m_valid = 0; m_out = 0; m_shift = 0; m_pend = 0;
      for (int k = 0; k < N; k++) begin
         m_active[k] = 0;
         m_shadow[k] = 0;
      end
      hist.delete();
   endtask

   task automatic model_step();
      bit     accept, proc;
      longint acc;
      int     nxt;
      if (rst) begin
         model_reset();
         return;
      end
      accept = coef_wr_valid && m_ready;
      proc   = sig_in_valid && (m_state == M_RUN || m_state == M_PEND);
      if (proc) begin
         hist.push_front(longint'($signed(sig_in)));
         if (hist.size() > N) void'(hist.pop_back());
         acc = 0;
         for (int k = 0; k < hist.size(); k++)
            acc += hist[k] * m_active[k];
         acc = acc >>> m_shift;
         if (acc > 127) begin
            m_out = 127; m_sat = 1;
         end else if (acc < -128) begin
            m_out = -128; m_sat = 1;
         end else begin
            m_out = acc;
         end
         m_valid = 1;
      end else begin
         m_valid = 0;
      end
      if (m_state == M_SWAP) begin
         m_active = m_shadow;
         m_bank   = ~m_bank;
         m_shift  = m_pend;
         hist.delete();
         m_loaded = 1;
         m_sat    = 0;
      end
      if (accept) begin
         if (int'(coef_wr_addr) < N)
            m_shadow[coef_wr_addr] = longint'($signed(coef_wr_data));
         else
            m_wrerr = 1;
      end
      if (coef_commit && (m_state == M_EMPTY || m_state == M_RUN))
         m_pend = int'(coef_shift);
      nxt = m_state;
      case (m_state)
         M_EMPTY: if (coef_commit) nxt = M_SWAP;
         M_RUN:   if (coef_commit) nxt = M_PEND;
         M_PEND:  if (!sig_in_valid) nxt = M_SWAP;
         default: nxt = M_RUN;
      endcase
      m_state = nxt;
      m_ready = (nxt == M_EMPTY || nxt == M_RUN);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("m_valid", longint'(sig_out_valid), longint'(m_valid));
            chk("m_ready", longint'(coef_wr_ready), longint'(m_ready));
            chk("m_bank", longint'(active_bank), longint'(m_bank));
            chk("m_loaded", longint'(coef_loaded), longint'(m_loaded));
            chk("m_sat", longint'(sat_flag), longint'(m_sat));
            chk("m_wrerr", longint'(wr_err), longint'(m_wrerr));
            if (m_valid)
               chk("m_sig_out", longint'($signed(sig_out)), m_out);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      sig_in_valid = 0; coef_wr_valid = 0; coef_commit = 0;
   endtask

   task automatic write(input int addr, input int data);
      coef_wr_valid = 1; coef_wr_addr = 3'(addr); coef_wr_data = 8'(data);
      step();
      coef_wr_valid = 0;
   endtask

   task automatic sample(input int x);
      sig_in_valid = 1; sig_in = 8'(x);
      step();
      sig_in_valid = 0;
   endtask

   int imp_exp [5] = '{56, 28, 14, 0, 0};

   initial begin
      idle();
      rst = 1;
      step();
      cmp_en = 1;
      step();
      rst = 0;
      chk("rst_ready", longint'(coef_wr_ready), 1);
      chk("rst_valid", longint'(sig_out_valid), 0);
      chk("rst_loaded", longint'(coef_loaded), 0);
      chk("rst_bank", longint'(active_bank), 0);
      chk("rst_sat", longint'(sat_flag), 0);
      chk("rst_wrerr", longint'(wr_err), 0);
      chk("rst_sig_out", longint'(sig_out), 0);

      // Input before any commit is dropped.
      sample(100);
      chk("empty_valid", longint'(sig_out_valid), 0);

      // Impulse taps; last write shares the cycle with the first commit.
      write(0, 64); write(1, 32); write(2, 16); write(3, 0);
      coef_wr_valid = 1; coef_wr_addr = 3'd4; coef_wr_data = 8'd0;
      coef_commit = 1; coef_shift = 5'd6;
      step();
      idle();
      chk("swap_ready", longint'(coef_wr_ready), 0);
      step();
      chk("load_loaded", longint'(coef_loaded), 1);
      chk("load_bank", longint'(active_bank), 1);
      for (int k = 0; k < 5; k++) begin
         sample(k == 0 ? 56 : 0);
         chk("imp_valid", longint'(sig_out_valid), 1);
         chk("imp_out", longint'($signed(sig_out)), longint'(imp_exp[k]));
      end
      step();
      chk("imp_idle_valid", longint'(sig_out_valid), 0);

      // Out-of-range write flags and leaves the taps alone.
      write(5, 99);
      chk("wr_err", longint'(wr_err), 1);
      sample(56);
      chk("wr_err_taps", longint'($signed(sig_out)), 56);

      // Saturation.
      write(0, 127); write(1, 0); write(2, 0);
      coef_commit = 1; coef_shift = 5'd0;
      step();
      idle();
      step();
      step();
      chk("sat_bank", longint'(active_bank), 0);
      sample(127);
      chk("sat_pos", longint'($signed(sig_out)), 127);
      chk("sat_flag", longint'(sat_flag), 1);
      sample(-128);
      chk("sat_neg", longint'($signed(sig_out)), -128);

      // Commit with a write in the same cycle, under a continuous stream.
      coef_wr_valid = 1; coef_wr_addr = 3'd0; coef_wr_data = 8'd32;
      coef_commit = 1; coef_shift = 5'd5;
      sig_in_valid = 1; sig_in = 8'd1;
      step();
      idle();
      for (int k = 0; k < 10; k++) begin
         sample(1);
         chk("pend_ready", longint'(coef_wr_ready), 0);
         chk("pend_out", longint'($signed(sig_out)), 127);
      end
      chk("pend_bank", longint'(active_bank), 0);
      step();
      sample(3);
      chk("swap_drop", longint'(sig_out_valid), 0);
      chk("swap_bank", longint'(active_bank), 1);
      chk("swap_sat_clr", longint'(sat_flag), 0);
      sample(3);
      chk("new_taps", longint'($signed(sig_out)), 3);
      sample(-5);
      chk("new_taps_neg", longint'($signed(sig_out)), -5);

      // Reset in the middle of a pending commit.
      coef_commit = 1; coef_shift = 5'd2;
      sig_in_valid = 1; sig_in = 8'd2;
      step();
      idle();
      sample(2);
      rst = 1;
      step();
      rst = 0;
      chk("rp_loaded", longint'(coef_loaded), 0);
      chk("rp_bank", longint'(active_bank), 0);
      chk("rp_valid", longint'(sig_out_valid), 0);
      chk("rp_ready", longint'(coef_wr_ready), 1);
      chk("rp_sat", longint'(sat_flag), 0);
      chk("rp_wrerr", longint'(wr_err), 0);
      sample(5);
      chk("rp_empty_drop", longint'(sig_out_valid), 0);

      // Random traffic; checked by the model on every cycle.
      for (int c = 0; c < 600; c++) begin
         coef_wr_valid = ($urandom_range(0, 99) < 30);
         coef_wr_addr  = 3'($urandom_range(0, 5));
         coef_wr_data  = 8'($urandom);
         coef_commit   = ($urandom_range(0, 99) < 5);
         coef_shift    = 5'($urandom_range(0, 9));
         sig_in_valid  = ((c % 100) < 30) ? 1'b1 : ($urandom_range(0, 99) < 70);
         sig_in        = 8'($urandom);
         step();
      end
      idle();
      step();
      step();
      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
